// File: rtl/pwm_capture.sv
// Memory-mapped PWM decoder: measures high time and rise-to-rise period of pwm_in in prescaled units.
// Edges are seen 3 clocks after pwm_in; captures are readable the clock after; reads are combinational with no backpressure.
module pwm_capture #(
   parameter int unsigned UNIT_CLKS    = 100,
   parameter int unsigned TIMEOUT_CLKS = 1_500_000,
   parameter logic [11:0] BASE_ADDR    = 12'd13
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        pwm_in,
   input  logic [11:0] addr,
   output logic [31:0] dataOut,
   output logic        hit
);

   localparam int PW = (UNIT_CLKS > 1) ? $clog2(UNIT_CLKS) : 1;
   localparam int IW = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [PW-1:0] PRES_MAX   = PW'(UNIT_CLKS - 1);
   // The rise-detect cycle is itself the first prescaled clock, so the unit
   // counters stay aligned to floor(N/UNIT_CLKS) rather than floor((N-1)/UNIT_CLKS).
   localparam logic [PW-1:0] PRES_START = PW'((UNIT_CLKS > 1) ? 1 : 0);
   localparam logic [9:0]    HI_START   = 10'((UNIT_CLKS > 1) ? 0 : 1);
   localparam logic [15:0]   PER_START  = 16'((UNIT_CLKS > 1) ? 0 : 1);
   localparam logic [IW-1:0] IDLE_MAX   = IW'(TIMEOUT_CLKS);
   localparam logic [IW-1:0] IDLE_LAST  = IW'(TIMEOUT_CLKS - 1);
   localparam logic [11:0]   PER_ADDR   = BASE_ADDR + 12'd1;

   typedef enum logic [1:0] {ARM, LOW_WAIT, HIGH} state_t;

   state_t        state_q, state_d;
   logic          sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
   logic [1:0]    fill_q, fill_d;
   logic [PW-1:0] pres_q, pres_d;
   logic [9:0]    hi_cnt_q, hi_cnt_d;
   logic [15:0]   per_cnt_q, per_cnt_d;
   logic [IW-1:0] idle_cnt_q, idle_cnt_d;
   logic [9:0]    width_q, width_d;
   logic [15:0]   per_q, per_d;
   logic [7:0]    cap_cnt_q, cap_cnt_d;
   logic          timeout_q, timeout_d;
   logic          have_rise_q, have_rise_d;
   logic          rise, fall, tick, to_event;

   always_comb begin
      sync1_d     = pwm_in;
      sync2_d     = sync1_q;
      prev_d      = sync2_q;
      rise        = sync2_q & ~prev_q;
      fall        = ~sync2_q & prev_q;
      tick        = (pres_q == PRES_MAX);
      // The sync chain holds reset zeros for two clocks; its level is trusted only after that.
      fill_d      = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;

      pres_d      = tick ? '0 : pres_q + PW'(1);
      hi_cnt_d    = hi_cnt_q;
      per_cnt_d   = per_cnt_q;
      if (tick && state_q == HIGH && hi_cnt_q != 10'h3FF)
         hi_cnt_d = hi_cnt_q + 10'd1;
      if (tick && state_q != ARM && per_cnt_q != 16'hFFFF)
         per_cnt_d = per_cnt_q + 16'd1;
      if (rise) begin
         pres_d    = PRES_START;
         hi_cnt_d  = HI_START;
         per_cnt_d = PER_START;
      end

      idle_cnt_d  = idle_cnt_q;
      if (rise || fall)
         idle_cnt_d = '0;
      else if (idle_cnt_q != IDLE_MAX)
         idle_cnt_d = idle_cnt_q + IW'(1);
      to_event    = !(rise || fall) && (idle_cnt_q == IDLE_LAST);

      state_d     = state_q;
      have_rise_d = have_rise_q;
      width_d     = width_q;
      per_d       = per_q;
      cap_cnt_d   = cap_cnt_q;
      timeout_d   = timeout_q;
      case (state_q)
         ARM: begin
            have_rise_d = 1'b0;
            if (fill_q == 2'd2 && !sync2_q)
               state_d = LOW_WAIT;
         end
         LOW_WAIT: begin
            if (rise) begin
               if (have_rise_q)
                  per_d = per_cnt_q;
               have_rise_d = 1'b1;
               state_d     = HIGH;
            end
         end
         HIGH: begin
            if (fall) begin
               width_d   = hi_cnt_q;
               cap_cnt_d = cap_cnt_q + 8'd1;
               timeout_d = 1'b0;
               state_d   = LOW_WAIT;
            end
         end
         default: state_d = ARM;
      endcase
      if (to_event) begin
         timeout_d   = 1'b1;
         have_rise_d = 1'b0;
         state_d     = sync2_q ? ARM : LOW_WAIT;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ARM;
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         prev_q      <= 1'b0;
         fill_q      <= '0;
         pres_q      <= '0;
         hi_cnt_q    <= '0;
         per_cnt_q   <= '0;
         idle_cnt_q  <= '0;
         width_q     <= '0;
         per_q       <= '0;
         cap_cnt_q   <= '0;
         timeout_q   <= 1'b0;
         have_rise_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         prev_q      <= prev_d;
         fill_q      <= fill_d;
         pres_q      <= pres_d;
         hi_cnt_q    <= hi_cnt_d;
         per_cnt_q   <= per_cnt_d;
         idle_cnt_q  <= idle_cnt_d;
         width_q     <= width_d;
         per_q       <= per_d;
         cap_cnt_q   <= cap_cnt_d;
         timeout_q   <= timeout_d;
         have_rise_q <= have_rise_d;
      end
   end

   always_comb begin
      dataOut = '0;
      hit     = 1'b0;
      if (addr == BASE_ADDR) begin
         hit     = 1'b1;
         dataOut = {timeout_q, 7'b0, cap_cnt_q, 6'b0, width_q};
      end else if (addr == PER_ADDR) begin
         hit     = 1'b1;
         dataOut = {16'b0, per_q};
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: scaled-down prescaler/timeout instance plus a unit-prescaler instance for saturation.
module tb_pwm_capture;

   localparam logic [11:0] A_ST  = 12'd13;
   localparam logic [11:0] A_PER = 12'd14;

   logic        clock;
   logic        reset;
   logic        pwm_in;
   logic [11:0] addr, addr_f;
   logic [31:0] data_m, data_f;
   logic        hit_m, hit_f;
   int          checks = 0;
   int          errors = 0;

   int th[5] = '{60, 60, 63, 64, 9};
   int tl[5] = '{140, 140, 141, 135, 191};
   int wm[5] = '{15, 15, 15, 16, 2};
   int pm[5] = '{0, 50, 50, 51, 49};
   int pf[5] = '{0, 200, 200, 204, 199};

   pwm_capture #(.UNIT_CLKS(4), .TIMEOUT_CLKS(5000), .BASE_ADDR(12'd13)) u_main (
      .clock(clock), .reset(reset), .pwm_in(pwm_in), .addr(addr), .dataOut(data_m), .hit(hit_m)
   );

   pwm_capture #(.UNIT_CLKS(1), .TIMEOUT_CLKS(200000), .BASE_ADDR(12'd13)) u_fast (
      .clock(clock), .reset(reset), .pwm_in(pwm_in), .addr(addr_f), .dataOut(data_f), .hit(hit_f)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] w0(input logic t, input logic [7:0] c, input logic [9:0] w);
      return {t, 7'b0, c, 6'b0, w};
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic rd_m(input string tag, input logic [11:0] a, input logic [31:0] exp);
      logic exp_hit;
      exp_hit = (a == 12'd13) || (a == 12'd14);
      addr = a;
      #1;
      checks++;
      assert (data_m === exp) else begin
         errors++;
         $error("FAIL %s main data: observed %h expected %h", tag, data_m, exp);
      end
      checks++;
      assert (hit_m === exp_hit) else begin
         errors++;
         $error("FAIL %s main hit: observed %b expected %b", tag, hit_m, exp_hit);
      end
   endtask

   task automatic rd_f(input string tag, input logic [11:0] a, input logic [31:0] exp);
      addr_f = a;
      #1;
      checks++;
      assert (data_f === exp) else begin
         errors++;
         $error("FAIL %s fast data: observed %h expected %h", tag, data_f, exp);
      end
   endtask

   initial begin
      reset  = 1'b1;
      pwm_in = 1'b0;
      addr   = A_ST;
      addr_f = A_ST;
      cyc(3);
      rd_m("rst_st", A_ST, 32'h0);
      rd_m("rst_per", A_PER, 32'h0);
      rd_m("rst_dec12", 12'd12, 32'h0);
      rd_f("rst_fast", A_ST, 32'h0);
      reset = 1'b0;
      cyc(5);

      // Nominal pulses, including a width that ends on a prescaler wrap.
      for (int i = 0; i < 5; i++) begin
         pwm_in = 1'b1;
         cyc(8);
         rd_m("nom_per", A_PER, 32'(pm[i]));
         rd_f("nom_per", A_PER, 32'(pf[i]));
         cyc(th[i] - 8);
         pwm_in = 1'b0;
         cyc(tl[i]);
         rd_m("nom_wid", A_ST, w0(1'b0, 8'(i + 1), 10'(wm[i])));
         rd_f("nom_wid", A_ST, w0(1'b0, 8'(i + 1), 10'(th[i])));
      end

      // Timeout on a held-low line.
      pwm_in = 1'b1;
      cyc(8);
      rd_m("to_per0", A_PER, 32'd50);
      rd_f("to_per0", A_PER, 32'd200);
      cyc(32);
      pwm_in = 1'b0;
      cyc(4960);
      rd_m("to_before", A_ST, w0(1'b0, 8'd6, 10'd10));
      cyc(60);
      rd_m("to_after", A_ST, w0(1'b1, 8'd6, 10'd10));
      rd_m("to_per_keep", A_PER, 32'd50);
      rd_f("to_fast_st", A_ST, w0(1'b0, 8'd6, 10'd40));
      pwm_in = 1'b1;
      cyc(8);
      rd_m("to_rise_per", A_PER, 32'd50);
      rd_m("to_rise_st", A_ST, w0(1'b1, 8'd6, 10'd10));
      rd_f("to_rise_per", A_PER, 32'd5060);
      cyc(40);
      pwm_in = 1'b0;
      cyc(150);
      rd_m("to_clear", A_ST, w0(1'b0, 8'd7, 10'd12));
      rd_f("to_clear", A_ST, w0(1'b0, 8'd7, 10'd48));
      pwm_in = 1'b1;
      cyc(8);
      rd_m("to_per_new", A_PER, 32'd49);
      rd_f("to_per_new", A_PER, 32'd198);
      cyc(32);
      pwm_in = 1'b0;
      cyc(100);
      rd_m("to_wid3", A_ST, w0(1'b0, 8'd8, 10'd10));

      // Reset in the middle of a high phase.
      pwm_in = 1'b1;
      cyc(20);
      reset = 1'b1;
      rd_m("mr_st", A_ST, 32'h0);
      rd_m("mr_per", A_PER, 32'h0);
      rd_f("mr_fast", A_ST, 32'h0);
      cyc(2);
      reset = 1'b0;
      cyc(20);
      pwm_in = 1'b0;
      cyc(50);
      rd_m("mr_nocap", A_ST, 32'h0);
      rd_m("mr_noper", A_PER, 32'h0);
      rd_f("mr_nocap", A_ST, 32'h0);
      pwm_in = 1'b1;
      cyc(80);
      pwm_in = 1'b0;
      cyc(100);
      rd_m("mr_full", A_ST, w0(1'b0, 8'd1, 10'd20));
      rd_m("mr_full_per", A_PER, 32'h0);
      rd_f("mr_full", A_ST, w0(1'b0, 8'd1, 10'd80));

      // Width and period saturation.
      pwm_in = 1'b1;
      cyc(8);
      rd_m("sat_per0", A_PER, 32'd45);
      rd_f("sat_per0", A_PER, 32'd180);
      cyc(4192);
      pwm_in = 1'b0;
      cyc(100);
      rd_m("sat_wid", A_ST, w0(1'b0, 8'd2, 10'd1023));
      rd_f("sat_wid", A_ST, w0(1'b0, 8'd2, 10'd1023));
      pwm_in = 1'b1;
      cyc(8);
      rd_m("sat_per1", A_PER, 32'd1075);
      rd_f("sat_per1", A_PER, 32'd4300);
      cyc(12);
      pwm_in = 1'b0;
      cyc(65520);
      pwm_in = 1'b1;
      cyc(8);
      rd_f("sat_per", A_PER, 32'd65535);
      rd_f("sat_st", A_ST, w0(1'b0, 8'd3, 10'd20));
      rd_m("sat_to_per", A_PER, 32'd1075);
      rd_m("sat_to_st", A_ST, w0(1'b1, 8'd3, 10'd5));
      cyc(12);
      pwm_in = 1'b0;
      cyc(20);

      // Capture-count wrap from a fresh reset.
      reset = 1'b1;
      cyc(2);
      reset = 1'b0;
      cyc(5);
      for (int i = 0; i < 255; i++) begin
         pwm_in = 1'b1;
         cyc(4);
         pwm_in = 1'b0;
         cyc(4);
      end
      cyc(10);
      rd_m("wrap_255", A_ST, w0(1'b0, 8'd255, 10'd1));
      rd_m("wrap_255_per", A_PER, 32'd2);
      rd_f("wrap_255", A_ST, w0(1'b0, 8'd255, 10'd4));
      rd_f("wrap_255_per", A_PER, 32'd8);
      pwm_in = 1'b1;
      cyc(4);
      pwm_in = 1'b0;
      cyc(10);
      rd_m("wrap_256", A_ST, w0(1'b0, 8'd0, 10'd1));
      rd_m("wrap_256_per", A_PER, 32'd4);
      pwm_in = 1'b1;
      cyc(4);
      pwm_in = 1'b0;
      cyc(10);
      rd_m("wrap_257", A_ST, w0(1'b0, 8'd1, 10'd1));
      rd_f("wrap_257", A_ST, w0(1'b0, 8'd1, 10'd4));

      // Address decode; unmatched reads must not disturb state.
      rd_m("dec_12", 12'd12, 32'h0);
      rd_m("dec_15", 12'd15, 32'h0);
      cyc(2);
      rd_m("dec_13", A_ST, w0(1'b0, 8'd1, 10'd1));
      rd_m("dec_14", A_PER, 32'd3);
      rd_f("dec_14", A_PER, 32'd14);
      rd_m("dec_0", 12'd0, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
